// File: rtl/flow_pkg.sv
// Shared defaults and helpers for the flow_pipe_log elastic pipeline.
package flow_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_DEPTH  = 3;
  localparam int unsigned DEF_LOG_AW = 2;

  // Bits needed to hold values 0..n-1; callers pass DEPTH+1 to size the occupancy count.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/flow_pipe_log_if.sv
// Valid/ready stream plus log side-port bundle for flow_pipe_log.
interface flow_pipe_log_if
  import flow_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned LOG_AW = DEF_LOG_AW
);

  localparam int unsigned CW = clog2(DEPTH + 1);

  logic              Valid_i;
  logic [WIDTH-1:0]  Data_i;
  logic              Ready_o;
  logic              Valid_o;
  logic [WIDTH-1:0]  Data_o;
  logic              Ready_i;
  logic [CW-1:0]     Count;
  logic [LOG_AW-1:0] Log_addr;
  logic [WIDTH-1:0]  Log_data;
  logic [LOG_AW-1:0] Log_ptr;
  logic              Log_wrapped;

  // Pipeline side.
  modport slave (
    input  Valid_i, Data_i, Ready_i, Log_addr,
    output Ready_o, Valid_o, Data_o, Count, Log_data, Log_ptr, Log_wrapped
  );

  // Source / sink / log reader side.
  modport master (
    output Valid_i, Data_i, Ready_i, Log_addr,
    input  Ready_o, Valid_o, Data_o, Count, Log_data, Log_ptr, Log_wrapped
  );

endinterface

// File: rtl/flow_stage.sv
// One elastic pipeline slot: valid bit plus data word, load-enabled, sync active-low clear.
module flow_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_q,
  output logic [WIDTH-1:0] d_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else if (load) begin
      v_q <= v_in;
      d_q <= d_in;
    end
  end

endmodule

// File: rtl/flow_pipe_log.sv
// Elastic valid/ready pipeline of DEPTH stages with bubble collapse; every delivered
// beat is also recorded in a circular log RAM readable through a side port.
module flow_pipe_log
  import flow_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned LOG_AW = DEF_LOG_AW
) (
  input logic            CLK,
  input logic            RESET_n,
  flow_pipe_log_if.slave bus
);

  localparam int unsigned CW    = clog2(DEPTH + 1);
  localparam int unsigned LOG_N = 2 ** LOG_AW;

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0][WIDTH-1:0] d;

  logic              in_hs;
  logic              out_hs;
  logic [CW-1:0]     count_q;
  logic [LOG_AW-1:0] ptr_q;
  logic              wrapped_q;
  logic [WIDTH-1:0]  log_data_q;
  logic [WIDTH-1:0]  mem [LOG_N];

  // Ready ripples back from the sink: a stage can take a beat if empty or if it empties this cycle.
  always_comb begin
    logic r;
    rdy = '0;
    r   = bus.Ready_i;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      r      = ~v[i] | r;
      rdy[i] = r;
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;

    if (i == 0) begin : g_head
      assign v_in = bus.Valid_i;
      assign d_in = bus.Data_i;
    end else begin : g_body
      assign v_in = v[i-1];
      assign d_in = d[i-1];
    end

    flow_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (CLK),
      .rst_n (RESET_n),
      .load  (rdy[i]),
      .v_in  (v_in),
      .d_in  (d_in),
      .v_q   (v[i]),
      .d_q   (d[i])
    );
  end

  assign in_hs  = bus.Valid_i & rdy[0];
  assign out_hs = v[DEPTH-1] & bus.Ready_i;

  // Occupancy count and log pointer/wrap bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      count_q    <= '0;
      ptr_q      <= '0;
      wrapped_q  <= 1'b0;
      log_data_q <= '0;
    end else begin
      case ({in_hs, out_hs})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (out_hs) begin
        ptr_q <= ptr_q + LOG_AW'(1);
        if (ptr_q == LOG_AW'(LOG_N - 1)) wrapped_q <= 1'b1;
      end
      log_data_q <= mem[bus.Log_addr];
    end
  end

  // Log storage is not reset; writes are suppressed during the reset cycle.
  always_ff @(posedge CLK) begin
    if (RESET_n && out_hs) mem[ptr_q] <= d[DEPTH-1];
  end

  assign bus.Ready_o     = rdy[0];
  assign bus.Valid_o     = v[DEPTH-1];
  assign bus.Data_o      = d[DEPTH-1];
  assign bus.Count       = count_q;
  assign bus.Log_data    = log_data_q;
  assign bus.Log_ptr     = ptr_q;
  assign bus.Log_wrapped = wrapped_q;

endmodule

// File: doc/flow_pipe_log.md
# flow_pipe_log

Parametrised elastic valid/ready pipeline of DEPTH register stages, WIDTH bits wide, with per-stage valid bits so bubbles collapse and throughput is one beat per cycle. Every beat delivered downstream is also written into a circular log RAM of 2^LOG_AW entries, readable through a side port. It replaces the fixed 3-stage, 8-bit flow-control pipeline between the data source and the downstream consumer in the homework datapath.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 3, number of pipeline stages (>=1)
- LOG_AW, 2, log RAM address width; 2^LOG_AW entries
- CLK  in  1  single clock; all state updates on rising edge
- RESET_n  in  1  reset, synchronous and active-low
- Valid_i  in  1  upstream beat valid
- Data_i  in  WIDTH  upstream data
- Ready_o  out  1  pipeline can accept a beat this cycle
- Valid_o  out  1  beat available at output
- Data_o  out  WIDTH  output data (stage DEPTH-1)
- Ready_i  in  1  downstream accepts beat this cycle
- Count  out  clog2(DEPTH+1)  number of valid stages
- Log_addr  in  LOG_AW  log read address
- Log_data  out  WIDTH  log read data (registered)
- Log_ptr  out  LOG_AW  next log write address
- Log_wrapped  out  1  sticky: log has wrapped at least once

## Operation
- Stage i holds v[i], d[i]; stage 0 fed by Data_i, stage DEPTH-1 drives Valid_o=v[DEPTH-1], Data_o=d[DEPTH-1].
- rdy[DEPTH-1] = !v[DEPTH-1] | Ready_i; rdy[i] = !v[i] | rdy[i+1]; Ready_o = rdy[0]. Combinational chain, no extra register.
- Stage i loads when rdy[i]: v[i] <= v[i-1] (Valid_i for i=0), d[i] <= d[i-1] (Data_i). When !rdy[i] stage holds.
- In-handshake: Valid_i & Ready_o. Out-handshake: Valid_o & Ready_i.
- Count: +1 on in-handshake only, -1 on out-handshake only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- Log: on out-handshake, RAM[Log_ptr] <= Data_o, Log_ptr <= Log_ptr+1 mod 2^LOG_AW. Log_wrapped set when Log_ptr advances from 2^LOG_AW-1 to 0; cleared only by reset.
- Log read: Log_data <= RAM[Log_addr] every cycle. Read and write same address same cycle returns old contents.
- Reset (RESET_n=0 at edge): all v[i]=0, all d[i]=0, Count=0, Log_ptr=0, Log_wrapped=0, Log_data=0. RAM contents not reset. Reset mid-transfer drops all in-flight beats; no log write in the reset cycle. Valid_i ignored while RESET_n=0.
- Outputs after reset: Valid_o=0, Data_o=0, Ready_o=1, Count=0.

## Timing
- Latency, empty pipe: beat accepted at edge N is in stage 0 after N; Valid_o high after edge N+DEPTH-1 (DEPTH cycles input to output).
- Throughput: one beat/cycle while Ready_i=1 and Valid_i=1.
- Full: all v=1 and Ready_i=0 -> Ready_o=0 same cycle (combinational); Data_o stable until out-handshake.
- Ready_i rising while full: Ready_o=1 same cycle; input and output handshake both occur, Count stays DEPTH.
- Log write visible on Log_data 2 edges after out-handshake edge when Log_addr points to it (write edge, then read edge).

## Structure
- Shared package/header flow_pkg: default WIDTH/DEPTH/LOG_AW and count-width function clog2.
- Sub-module flow_stage: one valid+data register with load enable and synchronous active-low clear; instantiated DEPTH times via generate.
- Log RAM inferred inside top as a simple dual-port array; pointer and wrap flag in top.

## Test plan
- Reset: hold RESET_n=0 two cycles with Valid_i=1 -> Valid_o=0, Ready_o=1, Count=0, Log_ptr=0, Log_wrapped=0.
- Streaming, DEPTH=3: send 0x11,0x22,0x33 back-to-back, Ready_i=1 -> Valid_o high cycles 3..5 with 0x11,0x22,0x33; Count peaks at 3.
- Backpressure: Ready_i=0, send 4 beats -> only 3 accepted, Ready_o=0, Count=3; raise Ready_i -> 4th accepted same cycle, order preserved.
- Bubble collapse: send beats with Valid_i gaps while Ready_i=0 -> beats pack to stages 2,1,0 with no gaps; Count equals beats sent.
- Log wrap, LOG_AW=2: deliver 5 beats 0xA0..0xA4 -> Log_ptr=1, Log_wrapped=1, RAM[0]=0xA4, RAM[1]=0xA1.
- Reset mid-operation: RESET_n=0 with 2 beats in flight -> next cycle Valid_o=0, Count=0, Log_ptr unchanged from 0 after reset, no further log writes.
